// File: rtl/scroll_char_buffer.sv
// Writable character buffer with modular scroll offset and time-multiplexed
// seven-segment digit scan; char/digit_an are registered one cycle behind state.
module scroll_char_buffer #(
  parameter int CHAR_W     = 4,
  parameter int ADDR_W     = 4,
  parameter int NUM_DIGITS = 4,
  parameter int DIG_W      = 2,
  parameter int SCROLL_DIV = 25000000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [CHAR_W-1:0]     wr_data,
  input  logic                  scroll_en,
  input  logic                  scroll_dir,
  input  logic                  step,
  output logic [ADDR_W-1:0]     offset,
  output logic [DIG_W-1:0]      digit_idx,
  output logic [CHAR_W-1:0]     char,
  output logic [NUM_DIGITS-1:0] digit_an
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SC_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int SN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CHAR_W-1:0]     mem_q [DEPTH];
  logic [CHAR_W-1:0]     mem_d [DEPTH];
  logic [SC_W-1:0]       scroll_cnt_q, scroll_cnt_d;
  logic [SN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [ADDR_W-1:0]     offset_q, offset_d;
  logic [DIG_W-1:0]      digit_idx_q, digit_idx_d;
  logic [CHAR_W-1:0]     char_q, char_d;
  logic [NUM_DIGITS-1:0] digit_an_q, digit_an_d;

  logic                  auto_tick;
  logic                  scan_tc;
  logic [ADDR_W-1:0]     rd_addr;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // auto_tick and step merge into a single advance request
  always_comb begin
    auto_tick    = scroll_en && (scroll_cnt_q == SC_W'(SCROLL_DIV - 1));
    scroll_cnt_d = '0;
    if (scroll_en && !auto_tick) begin
      scroll_cnt_d = scroll_cnt_q + SC_W'(1);
    end
    offset_d = offset_q;
    if (auto_tick || step) begin
      offset_d = scroll_dir ? offset_q - ADDR_W'(1) : offset_q + ADDR_W'(1);
    end
  end

  always_comb begin
    scan_tc     = (scan_cnt_q == SN_W'(SCAN_DIV - 1));
    scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + SN_W'(1);
    digit_idx_d = digit_idx_q;
    if (scan_tc) begin
      digit_idx_d = (digit_idx_q == DIG_W'(NUM_DIGITS - 1)) ? '0
                                                            : digit_idx_q + DIG_W'(1);
    end
  end

  // Reads use pre-write contents, so a same-cycle write shows up on the next visit
  always_comb begin
    rd_addr    = offset_q + ADDR_W'(digit_idx_q);
    char_d     = mem_q[rd_addr];
    digit_an_d = ~(NUM_DIGITS'(1) << digit_idx_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= CHAR_W'(i);
      end
      scroll_cnt_q <= '0;
      scan_cnt_q   <= '0;
      offset_q     <= '0;
      digit_idx_q  <= '0;
      char_q       <= '0;
      digit_an_q   <= '1;
    end else begin
      mem_q        <= mem_d;
      scroll_cnt_q <= scroll_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      offset_q     <= offset_d;
      digit_idx_q  <= digit_idx_d;
      char_q       <= char_d;
      digit_an_q   <= digit_an_d;
    end
  end

  assign offset    = offset_q;
  assign digit_idx = digit_idx_q;
  assign char      = char_q;
  assign digit_an  = digit_an_q;

endmodule

// File: tb/tb_scroll_char_buffer.sv
// Randomised bench for scroll_char_buffer against an integer-arithmetic model,
// plus directed literal expectations for scan order, stepping and reset.
module tb_scroll_char_buffer;

  localparam int CW = 4, AW = 4, ND = 4, DW = 2, SDIV = 4, NDIV = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic          scroll_en = 1'b0;
  logic          scroll_dir = 1'b0;
  logic          step = 1'b0;
  logic [AW-1:0] offset;
  logic [DW-1:0] digit_idx;
  logic [CW-1:0] char;
  logic [ND-1:0] digit_an;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // behavioural model state
  int mem_m [DEPTH];
  int off_m, dig_m, scnt_m, scan_m, ch_m, an_m;

  scroll_char_buffer #(
    .CHAR_W(CW), .ADDR_W(AW), .NUM_DIGITS(ND), .DIG_W(DW),
    .SCROLL_DIV(SDIV), .SCAN_DIV(NDIV)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .scroll_en(scroll_en), .scroll_dir(scroll_dir), .step(step),
    .offset(offset), .digit_idx(digit_idx), .char(char), .digit_an(digit_an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = i % 16;
    off_m = 0; dig_m = 0; scnt_m = 0; scan_m = 0; ch_m = 0; an_m = 15;
  endtask

  task automatic model_step();
    bit tick;
    tick = scroll_en && (scnt_m == SDIV - 1);
    ch_m = mem_m[(off_m + dig_m) % DEPTH];
    an_m = (~(1 << dig_m)) & 15;
    if (wr_en) mem_m[wr_addr] = wr_data;
    scnt_m = (scroll_en && !tick) ? scnt_m + 1 : 0;
    if (tick || step) off_m = scroll_dir ? (off_m + DEPTH - 1) % DEPTH : (off_m + 1) % DEPTH;
    if (scan_m == NDIV - 1) begin
      scan_m = 0;
      dig_m = (dig_m + 1) % ND;
    end else begin
      scan_m = scan_m + 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("offset", int'(offset), off_m);
      chk("digit_idx", int'(digit_idx), dig_m);
      chk("char", int'(char), ch_m);
      chk("digit_an", int'(digit_an), an_m);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_an(input logic [ND-1:0] an, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 24 && !ok; i++) begin
      @(negedge clk);
      if (digit_an == an) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: anode %b never seen, last %b", name, an, digit_an);
    end
  endtask

  // Reset asserted between edges must clear outputs without a clock edge
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    chk("rst_offset", int'(offset), 0);
    chk("rst_digit_an", int'(digit_an), 15);
    chk("rst_char", int'(char), 0);
    chk("rst_digit_idx", int'(digit_idx), 0);
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    logic [ND-1:0] an_lit [4];
    int off_before;
    bit found;
    an_lit = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    #1 reset = 1'b0;
    checking = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;

    // scan order straight out of reset, each digit held two clocks
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("scan_an", int'(digit_an), int'(an_lit[k/2]));
      chk("scan_char", int'(char), k / 2);
      chk("scan_offset", int'(offset), 0);
    end

    // manual step down from 0 wraps to 15
    cyc();
    scroll_dir = 1'b1;
    step = 1'b1;
    cyc();
    step = 1'b0;
    @(negedge clk);
    chk("step_wrap_offset", int'(offset), 15);
    cyc();
    wait_an(4'b1110, "wait_d0");
    chk("wrap_d0_char", int'(char), 15);
    wait_an(4'b1101, "wait_d1");
    chk("wrap_d1_char", int'(char), 0);

    // step coinciding with auto_tick yields a single advance
    cyc();
    scroll_dir = 1'b0;
    scroll_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc();
      if (scnt_m == SDIV - 1) found = 1'b1;
    end
    chk("tick_found", int'(found), 1);
    off_before = off_m;
    step = 1'b1;
    cyc();
    step = 1'b0;
    @(negedge clk);
    chk("tick_step_offset", int'(offset), (off_before + 1) % DEPTH);

    // write buf[5]=A, scroll to offset 9, then reset restores buffer
    cyc();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'hA;
    cyc();
    wr_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (off_m == 9) found = 1'b1;
    end
    chk("reach_offset9", int'(found), 1);
    pulse_reset();
    scroll_en = 1'b0;
    step = 1'b1;
    cyc();
    cyc();
    step = 1'b0;
    cyc();
    wait_an(4'b0111, "wait_d3");
    chk("offset_after_steps", int'(offset), 2);
    chk("buf5_restored", int'(char), 5);

    // randomised phase
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset();
      end
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = CW'($urandom_range(0, 15));
      scroll_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) scroll_dir = ~scroll_dir;
      step = ($urandom_range(0, 7) == 0);
    end
    cyc();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
